// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle controller: opcodes, FSM states and
// the select-field encodings seen by the register-file/ALU datapath.
package cpu_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_ALU_R    = 4'd2,
    S_ALU_I    = 4'd3,
    S_ALU_WB   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WB   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_ANDI = 4'h5;
  localparam logic [3:0] OP_LW   = 4'h8;
  localparam logic [3:0] OP_SW   = 4'h9;
  localparam logic [3:0] OP_BEQ  = 4'hA;
  localparam logic [3:0] OP_BNE  = 4'hB;
  localparam logic [3:0] OP_J    = 4'hC;
  localparam logic [3:0] OP_JAL  = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] WDAT_ALUOUT = 2'b00;
  localparam logic [1:0] WDAT_MEMO   = 2'b01;
  localparam logic [1:0] WDAT_PC     = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUB_REG   = 2'b00;
  localparam logic [1:0] ALUB_ONE   = 2'b01;
  localparam logic [1:0] ALUB_SEIMM = 2'b10;

  localparam logic [2:0] ALUOP_ADD = 3'b000;
  localparam logic [2:0] ALUOP_SUB = 3'b001;
  localparam logic [2:0] ALUOP_AND = 3'b010;
  localparam logic [2:0] ALUOP_OR  = 3'b011;

  function automatic logic opIsLegal(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI,
      OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_HALT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational decode of FSM state (plus opcode/zero flag where needed)
// into the datapath control strobes. Anything not set for a state stays 0.
module ctrl_decode
  import cpu_pkg::*;
(
  input  state_t     st,
  input  logic [3:0] irOp,
  input  logic       zero,
  output logic       IRwrtCTRL,
  output logic       memOWCTRL,
  output logic       RegWrtCTRL,
  output logic [1:0] wDatCTRL,
  output logic       wAdrsCTRL,
  output logic       useFirstRegCTRL,
  output logic       useRegCTRL,
  output logic       iorCTRL,
  output logic       memWrtCTRL,
  output logic       pcWrtCTRL,
  output logic [1:0] pcSrcCTRL,
  output logic       aluSrcACTRL,
  output logic [1:0] aluSrcBCTRL,
  output logic [2:0] aluOpCTRL,
  output logic       illegal,
  output logic       halted
);

  always_comb begin
    IRwrtCTRL       = 1'b0;
    memOWCTRL       = 1'b0;
    RegWrtCTRL      = 1'b0;
    wDatCTRL        = WDAT_ALUOUT;
    wAdrsCTRL       = 1'b0;
    useFirstRegCTRL = 1'b0;
    useRegCTRL      = 1'b0;
    iorCTRL         = 1'b0;
    memWrtCTRL      = 1'b0;
    pcWrtCTRL       = 1'b0;
    pcSrcCTRL       = PCSRC_ALU;
    aluSrcACTRL     = 1'b0;
    aluSrcBCTRL     = ALUB_REG;
    aluOpCTRL       = ALUOP_ADD;
    illegal         = 1'b0;
    halted          = 1'b0;

    case (st)
      S_FETCH: begin
        IRwrtCTRL   = 1'b1;
        pcWrtCTRL   = 1'b1;
        aluSrcBCTRL = ALUB_ONE;
      end
      S_DECODE: begin
        // Branch target is precomputed here so BRANCH only has to compare.
        useRegCTRL  = 1'b1;
        aluSrcBCTRL = ALUB_SEIMM;
        illegal     = !opIsLegal(irOp);
      end
      S_ALU_R: begin
        aluSrcACTRL = 1'b1;
        aluOpCTRL   = irOp[2:0];
      end
      S_ALU_I: begin
        aluSrcACTRL = 1'b1;
        aluSrcBCTRL = ALUB_SEIMM;
        aluOpCTRL   = (irOp == OP_ANDI) ? ALUOP_AND : ALUOP_ADD;
      end
      S_ALU_WB: begin
        RegWrtCTRL = 1'b1;
      end
      S_MEM_ADDR: begin
        aluSrcACTRL = 1'b1;
        aluSrcBCTRL = ALUB_SEIMM;
      end
      S_MEM_RD: begin
        iorCTRL   = 1'b1;
        memOWCTRL = 1'b1;
      end
      S_MEM_WB: begin
        RegWrtCTRL = 1'b1;
        wDatCTRL   = WDAT_MEMO;
        wAdrsCTRL  = 1'b1;
      end
      S_MEM_WR: begin
        iorCTRL    = 1'b1;
        memWrtCTRL = 1'b1;
      end
      S_BRANCH: begin
        aluSrcACTRL = 1'b1;
        aluOpCTRL   = ALUOP_SUB;
        pcSrcCTRL   = PCSRC_ALUOUT;
        pcWrtCTRL   = (irOp == OP_BNE) ? !zero : zero;
      end
      S_JUMP: begin
        pcSrcCTRL = PCSRC_JUMP;
        pcWrtCTRL = 1'b1;
        if (irOp == OP_JAL) begin
          RegWrtCTRL      = 1'b1;
          wDatCTRL        = WDAT_PC;
          useFirstRegCTRL = 1'b1;
        end
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM: state register and next-state logic; all strobes
// come from ctrl_decode and are combinational from the state register.
//
//  state    | meaning
//  FETCH    | load IR, PC <= PC+1
//  DECODE   | latch A/B, branch target into ALUOut, dispatch on opcode
//  ALU_R    | register-register ALU op
//  ALU_I    | register-immediate ALU op
//  ALU_WB   | write ALUOut to IR[11:8]
//  MEM_ADDR | effective address = A + SEIMM
//  MEM_RD   | read memory into MemO
//  MEM_WB   | write MemO to IR[7:4]
//  MEM_WR   | memory write
//  BRANCH   | compare, conditional PC <= ALUOut
//  JUMP     | PC <= jump target (JAL links to R0)
//  HALT     | stopped until RESET
module multicycle_control
  import cpu_pkg::*;
#(
  parameter int OPW = 4,
  parameter int STW = 4
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic [OPW-1:0] IR_OP,
  input  logic           ZERO,
  output logic           IRwrtCTRL,
  output logic           memOWCTRL,
  output logic           RegWrtCTRL,
  output logic [1:0]     wDatCTRL,
  output logic           wAdrsCTRL,
  output logic           useFirstRegCTRL,
  output logic           useRegCTRL,
  output logic           iorCTRL,
  output logic           memWrtCTRL,
  output logic           pcWrtCTRL,
  output logic [1:0]     pcSrcCTRL,
  output logic           aluSrcACTRL,
  output logic [1:0]     aluSrcBCTRL,
  output logic [2:0]     aluOpCTRL,
  output logic           illegal,
  output logic           halted,
  output logic [STW-1:0] state
);

  state_t stateQ, stateNext;

  always_ff @(posedge CLK) begin
    if (RESET) stateQ <= S_FETCH;
    else       stateQ <= stateNext;
  end

  always_comb begin
    stateNext = S_FETCH;
    case (stateQ)
      S_FETCH: stateNext = S_DECODE;
      S_DECODE: begin
        case (IR_OP)
          OP_ADD, OP_SUB, OP_AND, OP_OR: stateNext = S_ALU_R;
          OP_ADDI, OP_ANDI:              stateNext = S_ALU_I;
          OP_LW, OP_SW:                  stateNext = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                stateNext = S_BRANCH;
          OP_J, OP_JAL:                  stateNext = S_JUMP;
          OP_HALT:                       stateNext = S_HALT;
          default:                       stateNext = S_FETCH;
        endcase
      end
      S_ALU_R, S_ALU_I: stateNext = S_ALU_WB;
      S_MEM_ADDR:       stateNext = (IR_OP == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:         stateNext = S_MEM_WB;
      S_HALT:           stateNext = S_HALT;
      default:          stateNext = S_FETCH;
    endcase
  end

  assign state = STW'(stateQ);

  ctrl_decode uDecode (
    .st              (stateQ),
    .irOp            (IR_OP),
    .zero            (ZERO),
    .IRwrtCTRL       (IRwrtCTRL),
    .memOWCTRL       (memOWCTRL),
    .RegWrtCTRL      (RegWrtCTRL),
    .wDatCTRL        (wDatCTRL),
    .wAdrsCTRL       (wAdrsCTRL),
    .useFirstRegCTRL (useFirstRegCTRL),
    .useRegCTRL      (useRegCTRL),
    .iorCTRL         (iorCTRL),
    .memWrtCTRL      (memWrtCTRL),
    .pcWrtCTRL       (pcWrtCTRL),
    .pcSrcCTRL       (pcSrcCTRL),
    .aluSrcACTRL     (aluSrcACTRL),
    .aluSrcBCTRL     (aluSrcBCTRL),
    .aluOpCTRL       (aluOpCTRL),
    .illegal         (illegal),
    .halted          (halted)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed literal checks followed by random
// instruction streams compared every cycle against an instruction-level model.
module tb_multicycle_control;

  typedef int intq_t[$];

  logic       CLK, RESET, ZERO;
  logic [3:0] IR_OP;
  logic       IRwrtCTRL, memOWCTRL, RegWrtCTRL, wAdrsCTRL, useFirstRegCTRL;
  logic       useRegCTRL, iorCTRL, memWrtCTRL, pcWrtCTRL, aluSrcACTRL;
  logic       illegal, halted;
  logic [1:0] wDatCTRL, pcSrcCTRL, aluSrcBCTRL;
  logic [2:0] aluOpCTRL;
  logic [3:0] state;

  int passCnt = 0;
  int checkCnt = 0;
  int expSt = 0;
  intq_t plan;

  multicycle_control #(.OPW(4), .STW(4)) dut (
    .CLK(CLK), .RESET(RESET), .IR_OP(IR_OP), .ZERO(ZERO),
    .IRwrtCTRL(IRwrtCTRL), .memOWCTRL(memOWCTRL), .RegWrtCTRL(RegWrtCTRL),
    .wDatCTRL(wDatCTRL), .wAdrsCTRL(wAdrsCTRL), .useFirstRegCTRL(useFirstRegCTRL),
    .useRegCTRL(useRegCTRL), .iorCTRL(iorCTRL), .memWrtCTRL(memWrtCTRL),
    .pcWrtCTRL(pcWrtCTRL), .pcSrcCTRL(pcSrcCTRL), .aluSrcACTRL(aluSrcACTRL),
    .aluSrcBCTRL(aluSrcBCTRL), .aluOpCTRL(aluOpCTRL), .illegal(illegal),
    .halted(halted), .state(state)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // States visited after DECODE for each opcode; empty list means back to FETCH.
  function automatic intq_t planFor(input logic [3:0] op);
    intq_t q;
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3: q = '{2, 4};
      4'h4, 4'h5:             q = '{3, 4};
      4'h8:                   q = '{5, 6, 7};
      4'h9:                   q = '{5, 8};
      4'hA, 4'hB:             q = '{9};
      4'hC, 4'hD:             q = '{10};
      4'hF:                   q = '{11};
      default:                q = {};
    endcase
    return q;
  endfunction

  // Expected strobes, packed as
  // {IRwrt,memOW,RegWrt,wDat,wAdrs,useFirst,useReg,ior,memWrt,pcWrt,pcSrc,aluSrcA,aluSrcB,aluOp,illegal,halted}
  function automatic logic [20:0] expOut(input int st, input logic [3:0] op, input logic z);
    logic irw = 0, mow = 0, rw = 0, wa = 0, uf = 0, ur = 0, io = 0, mw = 0;
    logic pw = 0, asa = 0, il = 0, hl = 0;
    logic [1:0] wd = 0, ps = 0, asb = 0;
    logic [2:0] ao = 0;
    case (st)
      0:  begin irw = 1; pw = 1; asb = 2'd1; end
      1:  begin ur = 1; asb = 2'd2; il = (op == 4'h6 || op == 4'h7 || op == 4'hE); end
      2:  begin asa = 1; ao = op[2:0]; end
      3:  begin asa = 1; asb = 2'd2; ao = (op == 4'h5) ? 3'd2 : 3'd0; end
      4:  rw = 1;
      5:  begin asa = 1; asb = 2'd2; end
      6:  begin io = 1; mow = 1; end
      7:  begin rw = 1; wd = 2'd1; wa = 1; end
      8:  begin io = 1; mw = 1; end
      9:  begin asa = 1; ao = 3'd1; ps = 2'd1; pw = (op == 4'hA) ? z : !z; end
      10: begin ps = 2'd2; pw = 1; if (op == 4'hD) begin rw = 1; wd = 2'd2; uf = 1; end end
      11: hl = 1;
      default: ;
    endcase
    return {irw, mow, rw, wd, wa, uf, ur, io, mw, pw, ps, asa, asb, ao, il, hl};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checkCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic advanceModel();
    if (RESET) begin
      expSt = 0;
      plan.delete();
    end else begin
      case (expSt)
        0: expSt = 1;
        1: begin
          plan = planFor(IR_OP);
          expSt = (plan.size() > 0) ? plan.pop_front() : 0;
        end
        11: expSt = 11;
        default: expSt = (plan.size() > 0) ? plan.pop_front() : 0;
      endcase
    end
  endtask

  task automatic checkAll();
    logic [20:0] got;
    got = {IRwrtCTRL, memOWCTRL, RegWrtCTRL, wDatCTRL, wAdrsCTRL, useFirstRegCTRL,
           useRegCTRL, iorCTRL, memWrtCTRL, pcWrtCTRL, pcSrcCTRL, aluSrcACTRL,
           aluSrcBCTRL, aluOpCTRL, illegal, halted};
    chk("model_state", 32'(state), 32'(expSt));
    chk("model_outputs", 32'(got), 32'(expOut(expSt, IR_OP, ZERO)));
    if (RegWrtCTRL && memWrtCTRL) chk("one_write_strobe", 32'(2), 32'(1));
  endtask

  task automatic step();
    @(posedge CLK);
    advanceModel();
    @(negedge CLK);
    checkAll();
  endtask

  logic [3:0] op;

  initial begin
    RESET = 1'b1; IR_OP = 4'h0; ZERO = 1'b0;
    step(); step();
    RESET = 1'b0;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_irwrt", 32'(IRwrtCTRL), 32'd1);
    chk("rst_pcwrt", 32'(pcWrtCTRL), 32'd1);

    // R-type ADD
    step(); chk("rt_s1", 32'(state), 32'd1);
    step(); chk("rt_s2", 32'(state), 32'd2);
    chk("rt_regwrt_early", 32'(RegWrtCTRL), 32'd0);
    step(); chk("rt_s4", 32'(state), 32'd4);
    chk("rt_regwrt", 32'(RegWrtCTRL), 32'd1);
    chk("rt_wdat", 32'(wDatCTRL), 32'd0);
    step(); chk("rt_back", 32'(state), 32'd0);

    // LW
    IR_OP = 4'h8;
    step(); step(); chk("lw_s5", 32'(state), 32'd5);
    step(); chk("lw_s6", 32'(state), 32'd6);
    chk("lw_memow", 32'(memOWCTRL), 32'd1);
    step(); chk("lw_s7", 32'(state), 32'd7);
    chk("lw_wdat", 32'(wDatCTRL), 32'd1);
    chk("lw_wadrs", 32'(wAdrsCTRL), 32'd1);
    step(); chk("lw_back", 32'(state), 32'd0);

    // BEQ taken, then BNE not taken, both with ZERO=1
    IR_OP = 4'hA; ZERO = 1'b1;
    step(); step(); chk("beq_s9", 32'(state), 32'd9);
    chk("beq_pcwrt", 32'(pcWrtCTRL), 32'd1);
    step(); chk("beq_back", 32'(state), 32'd0);
    IR_OP = 4'hB;
    step(); step(); chk("bne_s9", 32'(state), 32'd9);
    chk("bne_pcwrt", 32'(pcWrtCTRL), 32'd0);
    step(); chk("bne_back", 32'(state), 32'd0);
    ZERO = 1'b0;

    // JAL
    IR_OP = 4'hD;
    step(); step(); chk("jal_s10", 32'(state), 32'd10);
    chk("jal_regwrt", 32'(RegWrtCTRL), 32'd1);
    chk("jal_usefirst", 32'(useFirstRegCTRL), 32'd1);
    chk("jal_wdat", 32'(wDatCTRL), 32'd2);
    chk("jal_pcsrc", 32'(pcSrcCTRL), 32'd2);
    step(); chk("jal_back", 32'(state), 32'd0);

    // Illegal opcode: one-cycle pulse, then FETCH
    IR_OP = 4'h7;
    step(); chk("ill_pulse", 32'(illegal), 32'd1);
    step(); chk("ill_back", 32'(state), 32'd0);
    chk("ill_gone", 32'(illegal), 32'd0);

    // HALT holds for 20 cycles until RESET
    IR_OP = 4'hF;
    step(); step(); chk("halt_s11", 32'(state), 32'd11);
    for (int i = 0; i < 20; i++) begin
      step(); chk("halt_hold", 32'(halted), 32'd1);
    end
    RESET = 1'b1;
    step(); RESET = 1'b0;
    chk("halt_reset", 32'(state), 32'd0);

    // SW aborted by RESET in MEM_WR
    IR_OP = 4'h9;
    step(); step(); step(); chk("sw_s8", 32'(state), 32'd8);
    chk("sw_memwrt", 32'(memWrtCTRL), 32'd1);
    RESET = 1'b1;
    step(); RESET = 1'b0;
    chk("sw_abort_state", 32'(state), 32'd0);
    chk("sw_abort_memwrt", 32'(memWrtCTRL), 32'd0);

    // Random instruction stream with occasional resets
    for (int c = 0; c < 3000; c++) begin
      ZERO = 1'($urandom_range(0, 1));
      if (expSt == 11) RESET = ($urandom_range(0, 5) == 0);
      else             RESET = ($urandom_range(0, 59) == 0);
      if (expSt == 0) begin
        op = 4'($urandom_range(0, 15));
        if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'($urandom_range(0, 3));
        IR_OP = op;
      end
      step();
    end

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
